pe_multichannel: RTL and testbench
==================================

// Module: pe_multichannel
// PURPOSE
//  Parametrised successor of the single-image PE: computes a KxK convolution summed across NUM_CH input
//  channels for every output pixel, with optional ReLU. Sits between the layer controller (image memory
//  read port, filter load port) and the next layer. Results stream out through a valid/ready FIFO with
//  backpressure instead of a flat memory array.
// PARAMETERS
//  NUM_CH          4   input channels processed in parallel (one multiplier per channel)
//  IMG_SIZE        16  square input image side, pixels
//  K               4   square filter side
//  STRIDE          1   window step, rows and columns
//  DW              8   pixel/filter width; pixels unsigned, filter taps signed two's complement
//  AW              32  accumulator/result width, signed
//  FIFO_DEPTH      8   result FIFO entries (power of two)
// PORTS
//  clk          in   1               clock, rising edge
//  rst_n        in   1               asynchronous reset, active low
//  start        in   1               one-cycle pulse; begins a full-image pass (ignored while busy)
//  relu_en      in   1               sampled at start; 1 = clamp negative results to 0
//  flt_wr_en    in   1               filter tap write strobe (ignored while busy)
//  flt_wr_ch    in   $clog2(NUM_CH)  channel of the tap written
//  flt_wr_idx   in   $clog2(K*K)     tap index, row-major (ky*K+kx)
//  flt_wr_data  in   DW              tap value
//  img_rd_en    out  1               image memory read strobe
//  img_rd_addr  out  $clog2(IMG_SIZE*IMG_SIZE)  pixel address, row-major, same for all channels
//  img_rd_data  in   NUM_CH*DW       channel c in bits [c*DW +: DW]; valid exactly 1 cycle after img_rd_en
//  res_valid    out  1               FIFO head valid
//  res_ready    in   1               consumer accepts head when res_valid & res_ready
//  res_data     out  AW              result, signed
//  res_last     out  1               head is the final output of the pass
//  busy         out  1               high from the cycle after start until done
//  done         out  1               one-cycle pulse: last result consumed, FIFO empty
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO emptied, accumulator and all filter taps cleared to 0.
//  - O = (IMG_SIZE-K)/STRIDE+1; outputs produced row-major (r,c), r,c in 0..O-1; O*O results per pass.
//  - Tap i=(ky,kx): addr = (r*STRIDE+ky)*IMG_SIZE + c*STRIDE+kx, taps issued in order i=0..K*K-1.
//  - Per tap: acc += sum_c( $signed({1'b0,pix_c}) * flt[c][i] ), sign-extended to AW, wraps mod 2^AW.
//  - FSM: IDLE -(start)-> FETCH -(last tap issued)-> ACC_LAST -> PUSH -(FIFO not full)-> FETCH next
//    output | FLUSH after last output; FLUSH -(FIFO empty)-> IDLE with done pulse.
//  - Timing, start sampled at edge 0: tap i issued in cycle i+1; accumulated in cycle i+2; PUSH in cycle
//    K*K+2; res_valid rises cycle K*K+3 (19 for K=4). Next output's FETCH starts in the cycle after PUSH,
//    so sustained throughput is one result per K*K+2 cycles.
//  - Accumulator cleared in the cycle the first tap of each output is issued.
//  - PUSH with FIFO full: stay in PUSH, no reads issued, accumulator held; simultaneous pop frees the slot
//    and the push completes that same cycle.
//  - ReLU applied at push; res_last stored per entry, set only on output (O-1,O-1).
//  - start while busy, flt_wr_en while busy: ignored, no side effect. start and flt_wr_en in same idle
//    cycle: filter write performed, then pass starts with the new tap.
//  - rst_n low mid-pass: immediate abort; pending FIFO entries lost; no done pulse.
// STRUCTURE
//  - Package pe_pkg: state enum pe_state_t {IDLE,FETCH,ACC_LAST,PUSH,FLUSH}; function out_dim(IMG_SIZE,K,STRIDE).
//  - Sub-module res_fifo (sync FIFO, width AW+1, depth FIFO_DEPTH, registered head, async rst_n).
//  - Top holds FSM, row/col/tap counters, filter register file, NUM_CH multiplier adder tree, accumulator.
// TESTING
//  1 All pixels 1, all taps 1, NUM_CH=4, K=4: 169 results each 64; res_last on #169 only; done pulse once.
//  2 All taps -1, pixels 1: relu_en=0 -> every res_data 32'hFFFFFFC0; relu_en=1 -> every result 0.
//  3 res_ready low from start: exactly 8 results queued, img_rd_en stays low, busy high; release ->
//    169 results in row-major order, none lost or duplicated.
//  4 STRIDE=2 build: 49 results; 2nd output's first img_rd_addr = 2, first of row 1 = 32; ramp image checked vs model.
//  5 rst_n low at cycle 50: res_valid, busy, img_rd_en 0 same cycle; taps read back as 0 (result 0); restart passes.
//  6 start and flt_wr_en pulsed at cycle 10 of a pass: no restart, taps unchanged, results match test 1.

Source files
------------

// File: rtl/pe_multichannel_pkg.sv
// Shared types and helpers for the multichannel convolution PE.
//   pe_state_t : controller states
//   out_dim()  : output feature-map side for a given image, filter and stride
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ACC_LAST,
        PUSH,
        FLUSH
    } pe_state_t;

    function automatic int out_dim(input int img_size, input int k, input int stride);
        return (img_size - k) / stride + 1;
    endfunction

endpackage

// File: rtl/pe_multichannel_if.sv
// Result stream between the PE and the next layer.
//   res_valid : head of result FIFO is valid          (producer -> consumer)
//   res_ready : consumer takes head on valid & ready  (consumer -> producer)
//   res_data  : signed result                         (producer -> consumer)
//   res_last  : head is final output of the pass      (producer -> consumer)
interface pe_multichannel_if #(
    parameter int AW = 32
);
    logic                 res_valid;
    logic                 res_ready;
    logic signed [AW-1:0] res_data;
    logic                 res_last;

    modport master (output res_valid, output res_data, output res_last, input res_ready);
    modport slave  (input res_valid, input res_data, input res_last, output res_ready);
endinterface

// File: rtl/pe_multichannel_res_fifo.sv
// Synchronous result FIFO with a registered storage head.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write push_data (accepted when not full, or when full with a pop this cycle)
//   pop        : remove head (ignored when empty)
//   head       : current head entry, zero while empty
//   empty/full : occupancy flags
module res_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pe_multichannel.sv
// KxK convolution summed over NUM_CH input channels, one result per output pixel,
// with optional ReLU, streamed out through a valid/ready result FIFO.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, relu_en      : begin a full-image pass; relu_en captured with start
//   flt_wr_*            : filter tap write port (idle only)
//   img_rd_en/addr/data : image memory read port, data returned one cycle after en
//   res                 : result stream (valid/ready/data/last)
//   busy, done          : pass in progress; one-cycle pulse when the pass has drained
module pe_multichannel
    import pe_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IMG_SIZE   = 16,
    parameter int K          = 4,
    parameter int STRIDE     = 1,
    parameter int DW         = 8,
    parameter int AW         = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  relu_en,
    input  logic                                  flt_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]             flt_wr_ch,
    input  logic [$clog2(K*K)-1:0]                flt_wr_idx,
    input  logic [DW-1:0]                         flt_wr_data,
    output logic                                  img_rd_en,
    output logic [$clog2(IMG_SIZE*IMG_SIZE)-1:0]  img_rd_addr,
    input  logic [NUM_CH*DW-1:0]                  img_rd_data,
    pe_multichannel_if.master                     res,
    output logic                                  busy,
    output logic                                  done
);
    localparam int O    = out_dim(IMG_SIZE, K, STRIDE);
    localparam int TAPS = K * K;
    localparam int TW   = $clog2(TAPS);
    localparam int AD_W = $clog2(IMG_SIZE * IMG_SIZE);
    localparam int CW   = $clog2(IMG_SIZE) + 1;

    localparam logic [CW-1:0] K_LAST = CW'(K - 1);
    localparam logic [CW-1:0] O_LAST = CW'(O - 1);

    pe_state_t              state;
    logic [CW-1:0]          row;
    logic [CW-1:0]          col;
    logic [CW-1:0]          ky;
    logic [CW-1:0]          kx;
    logic                   relu_q;
    logic signed [DW-1:0]   flt [NUM_CH][TAPS];
    logic signed [AW-1:0]   acc;

    logic                   vld_p1;
    logic [TW-1:0]          tap_p1;

    logic signed [2*DW:0]   prod [NUM_CH];
    logic signed [AW-1:0]   tap_sum;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_pop;
    logic                   push_ok;
    logic                   last_out;
    logic [AW:0]            fifo_head;

    function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] x, input logic en);
        return (en && x[AW-1]) ? '0 : x;
    endfunction

    assign busy      = (state != IDLE);
    assign img_rd_en = (state == FETCH);

    always_comb begin
        img_rd_addr = '0;
        if (state == FETCH) begin
            img_rd_addr = AD_W'((int'(row) * STRIDE + int'(ky)) * IMG_SIZE
                                + int'(col) * STRIDE + int'(kx));
        end
    end

    // ---- stage p1: pixel data returned for the tap issued last cycle ----
    always_comb begin
        tap_sum = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c] = $signed({1'b0, img_rd_data[c*DW +: DW]}) * flt[c][tap_p1];
            tap_sum = tap_sum + AW'(prod[c]);
        end
    end

    assign last_out = (row == O_LAST) && (col == O_LAST);
    assign fifo_pop = res.res_ready && !fifo_empty;
    assign push_ok  = (state == PUSH) && (!fifo_full || fifo_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            ky     <= '0;
            kx     <= '0;
            relu_q <= 1'b0;
            done   <= 1'b0;
            vld_p1 <= 1'b0;
            tap_p1 <= '0;
            acc    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int i = 0; i < TAPS; i++) begin
                    flt[c][i] <= '0;
                end
            end
        end else begin
            done   <= 1'b0;
            vld_p1 <= (state == FETCH);
            tap_p1 <= TW'(int'(ky) * K + int'(kx));
            if (vld_p1) begin
                acc <= acc + tap_sum;
            end

            case (state)
                IDLE: begin
                    // Filter write lands before the pass reads any tap, so a
                    // same-cycle start uses the new value.
                    if (flt_wr_en) begin
                        flt[flt_wr_ch][flt_wr_idx] <= flt_wr_data;
                    end
                    if (start) begin
                        state  <= FETCH;
                        relu_q <= relu_en;
                        row    <= '0;
                        col    <= '0;
                        ky     <= '0;
                        kx     <= '0;
                    end
                end
                FETCH: begin
                    // No product is in flight on the first tap, so clearing wins cleanly.
                    if (ky == '0 && kx == '0) begin
                        acc <= '0;
                    end
                    if (kx == K_LAST) begin
                        kx <= '0;
                        if (ky == K_LAST) begin
                            ky    <= '0;
                            state <= ACC_LAST;
                        end else begin
                            ky <= ky + 1'b1;
                        end
                    end else begin
                        kx <= kx + 1'b1;
                    end
                end
                ACC_LAST: begin
                    state <= PUSH;
                end
                PUSH: begin
                    if (push_ok) begin
                        if (last_out) begin
                            state <= FLUSH;
                        end else begin
                            state <= FETCH;
                            if (col == O_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (fifo_empty) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    res_fifo #(
        .W     (AW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data ({last_out, relu(acc, relu_q)}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign res.res_valid = !fifo_empty;
    assign res.res_data  = fifo_head[AW-1:0];
    assign res.res_last  = fifo_head[AW];
endmodule

// File: tb/tb_pe_multichannel.sv
module tb_pe_multichannel;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, relu_en;
    logic        flt_wr_en;
    logic [1:0]  flt_wr_ch;
    logic [3:0]  flt_wr_idx;
    logic [7:0]  flt_wr_data;
    logic        img_rd_en_a, img_rd_en_b;
    logic [7:0]  img_rd_addr_a, img_rd_addr_b;
    logic [31:0] img_rd_data_a, img_rd_data_b;
    logic        busy_a, busy_b, done_a, done_b;

    int n_vec = 0;
    int n_err = 0;
    int pixmode = 0;

    logic [31:0] qa_data[$];
    bit          qa_last[$];
    logic [31:0] qb_data[$];
    bit          qb_last[$];
    logic [7:0]  qb_addr[$];
    int          done_a_cnt = 0;
    int          done_b_cnt = 0;

    pe_multichannel_if #(.AW(32)) res_a ();
    pe_multichannel_if #(.AW(32)) res_b ();

    always #5 clk = ~clk;

    pe_multichannel dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .relu_en(relu_en),
        .flt_wr_en(flt_wr_en), .flt_wr_ch(flt_wr_ch), .flt_wr_idx(flt_wr_idx),
        .flt_wr_data(flt_wr_data), .img_rd_en(img_rd_en_a), .img_rd_addr(img_rd_addr_a),
        .img_rd_data(img_rd_data_a), .res(res_a), .busy(busy_a), .done(done_a)
    );

    pe_multichannel #(.STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .relu_en(relu_en),
        .flt_wr_en(flt_wr_en), .flt_wr_ch(flt_wr_ch), .flt_wr_idx(flt_wr_idx),
        .flt_wr_data(flt_wr_data), .img_rd_en(img_rd_en_b), .img_rd_addr(img_rd_addr_b),
        .img_rd_data(img_rd_data_b), .res(res_b), .busy(busy_b), .done(done_b)
    );

    // mode 0: flat image of ones; mode 1: ramp, offset per channel
    function automatic int pix(input int mode, input int addr, input int ch);
        return (mode == 0) ? 1 : ((addr + 16 * ch) & 255);
    endfunction

    function automatic logic [31:0] model(input int mode, input int stride, input int r,
                                          input int c, input int t, input bit relu);
        int s;
        s = 0;
        for (int ch = 0; ch < 4; ch++)
            for (int ky = 0; ky < 4; ky++)
                for (int kx = 0; kx < 4; kx++)
                    s += pix(mode, (r * stride + ky) * 16 + c * stride + kx, ch) * t;
        if (relu && s < 0) s = 0;
        return 32'(s);
    endfunction

    // image memories: one-cycle read latency
    always @(posedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (img_rd_en_a) img_rd_data_a[ch*8 +: 8] <= 8'(pix(pixmode, int'(img_rd_addr_a), ch));
            if (img_rd_en_b) img_rd_data_b[ch*8 +: 8] <= 8'(pix(pixmode, int'(img_rd_addr_b), ch));
        end
    end

    always @(negedge clk) begin
        if (res_a.res_valid && res_a.res_ready) begin
            qa_data.push_back(res_a.res_data);
            qa_last.push_back(res_a.res_last);
        end
        if (res_b.res_valid && res_b.res_ready) begin
            qb_data.push_back(res_b.res_data);
            qb_last.push_back(res_b.res_last);
        end
        if (img_rd_en_b) qb_addr.push_back(img_rd_addr_b);
        if (done_a) done_a_cnt++;
        if (done_b) done_b_cnt++;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        qa_data.delete(); qa_last.delete();
        qb_data.delete(); qb_last.delete(); qb_addr.delete();
        done_a_cnt = 0;
        done_b_cnt = 0;
    endtask

    task automatic load_taps(input logic [7:0] v);
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++) begin
                @(posedge clk); #1;
                flt_wr_en = 1'b1; flt_wr_ch = 2'(c); flt_wr_idx = 4'(i); flt_wr_data = v;
            end
        end
        @(posedge clk); #1;
        flt_wr_en = 1'b0;
    endtask

    // Returns 1 ns into cycle 1 (start sampled at edge 0).
    task automatic start_pass(input bit b_sel, input bit relu);
        @(posedge clk); #1;
        if (b_sel) start_b = 1'b1; else start_a = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit b_sel, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((b_sel ? done_b_cnt : done_a_cnt) != 0) break;
        end
        repeat (5) @(negedge clk);
        check({tag, "_done"}, b_sel ? done_b_cnt : done_a_cnt, 1);
    endtask

    task automatic check_pass(input string tag, input bit b_sel, input int mode,
                              input int stride, input int t, input bit relu);
        int o, n, bad;
        logic [31:0] d;
        bit l;
        o   = (16 - 4) / stride + 1;
        bad = 0;
        n   = b_sel ? qb_data.size() : qa_data.size();
        check({tag, "_count"}, n, o * o);
        for (int i = 0; i < n && i < o * o; i++) begin
            d = b_sel ? qb_data[i] : qa_data[i];
            l = b_sel ? qb_last[i] : qa_last[i];
            if (d !== model(mode, stride, i / o, i % o, t, relu) || l !== (i == o * o - 1)) bad++;
        end
        check({tag, "_bad_entries"}, bad, 0);
    endtask

    initial begin
        int n;
        int hi;
        logic en1;
        logic [7:0] addr1, addr2, addr5;

        rst_n = 1'b0; start_a = 0; start_b = 0; relu_en = 0;
        flt_wr_en = 0; flt_wr_ch = 0; flt_wr_idx = 0; flt_wr_data = 0;
        res_a.res_ready = 1'b1; res_b.res_ready = 1'b1;
        en1 = 0; addr1 = 0; addr2 = 0; addr5 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", res_a.res_valid, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_img_rd_en", img_rd_en_a, 0);
        check("rst_res_data", res_a.res_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Test 1: flat image, taps 1 -> every result 4*16 = 64
        load_taps(8'd1);
        pixmode = 0;
        clear_mon();
        start_pass(0, 0);
        for (n = 1; n < 40; n++) begin
            @(negedge clk);
            if (n == 1) begin en1 = img_rd_en_a; addr1 = img_rd_addr_a; end
            if (n == 2) addr2 = img_rd_addr_a;
            if (n == 5) addr5 = img_rd_addr_a;
            if (res_a.res_valid) break;
        end
        check("t1_rd_en_cycle1", en1, 1);
        check("t1_addr_tap0", addr1, 0);
        check("t1_addr_tap1", addr2, 1);
        check("t1_addr_tap4", addr5, 16);
        check("t1_first_valid_cycle", n, 19);
        check("t1_busy", busy_a, 1);
        wait_done("t1", 0, 6000);
        check("t1_first_value", qa_data.size() > 0 ? qa_data[0] : 32'hDEAD, 64);
        check_pass("t1", 0, 0, 1, 1, 0);
        check("t1_idle_after", busy_a, 0);

        // Test 2: taps -1 -> -64 without ReLU, 0 with ReLU
        load_taps(8'hFF);
        clear_mon();
        start_pass(0, 0);
        wait_done("t2a", 0, 6000);
        check("t2a_first_value", qa_data.size() > 0 ? qa_data[0] : 32'hDEAD, 32'hFFFFFFC0);
        check_pass("t2a", 0, 0, 1, -1, 0);
        clear_mon();
        start_pass(0, 1);
        wait_done("t2b", 0, 6000);
        check("t2b_first_value", qa_data.size() > 0 ? qa_data[0] : 32'hDEAD, 0);
        check_pass("t2b", 0, 0, 1, -1, 1);

        // Test 3: backpressure from the start, ramp image
        load_taps(8'd1);
        pixmode = 1;
        clear_mon();
        res_a.res_ready = 1'b0;
        start_pass(0, 0);
        repeat (300) @(negedge clk);
        check("t3_none_taken", qa_data.size(), 0);
        check("t3_valid_held", res_a.res_valid, 1);
        check("t3_busy_held", busy_a, 1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (img_rd_en_a) hi++;
        end
        check("t3_rd_en_stalled", hi, 0);
        @(posedge clk); #1;
        res_a.res_ready = 1'b1;
        // 8 queued plus the stalled push that lands on the first pop
        repeat (12) @(negedge clk);
        check("t3_burst_after_release", qa_data.size(), 9);
        wait_done("t3", 0, 6000);
        check("t3_first_value", qa_data.size() > 0 ? qa_data[0] : 32'hDEAD, 3168);
        check_pass("t3", 0, 1, 1, 1, 0);

        // Test 4: stride-2 instance, ramp image
        clear_mon();
        start_pass(1, 0);
        wait_done("t4", 1, 3000);
        check("t4_addr_count", qb_addr.size(), 49 * 16);
        check("t4_out1_first_addr", qb_addr.size() > 16 ? int'(qb_addr[16]) : -1, 2);
        check("t4_row1_first_addr", qb_addr.size() > 112 ? int'(qb_addr[112]) : -1, 32);
        check_pass("t4", 1, 1, 2, 1, 0);

        // Test 6: start and filter write during a pass are ignored
        pixmode = 0;
        clear_mon();
        start_pass(0, 0);
        repeat (8) @(posedge clk);
        #1;
        start_a = 1'b1; flt_wr_en = 1'b1; flt_wr_ch = 0; flt_wr_idx = 0; flt_wr_data = 8'd5;
        @(posedge clk); #1;
        start_a = 1'b0; flt_wr_en = 1'b0;
        wait_done("t6", 0, 6000);
        check_pass("t6", 0, 0, 1, 1, 0);

        // Test 5: reset mid-pass, taps cleared, restart
        clear_mon();
        res_a.res_ready = 1'b0;
        start_pass(0, 0);
        repeat (49) @(posedge clk);
        #1;
        check("t5_valid_before_rst", res_a.res_valid, 1);
        check("t5_busy_before_rst", busy_a, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_res_valid", res_a.res_valid, 0);
        check("t5_rst_busy", busy_a, 0);
        check("t5_rst_img_rd_en", img_rd_en_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        res_a.res_ready = 1'b1;
        check("t5_no_done_on_abort", done_a_cnt, 0);
        clear_mon();
        start_pass(0, 0);
        wait_done("t5", 0, 6000);
        check_pass("t5", 0, 0, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
